// File: rtl/lsu_dtcm_ctrl_if.sv
// Bundle of the AGU command channel, DTCM macro pins and write-back completion channel.
// slave = the load/store controller; master = the surrounding EXU/DTCM environment.
interface lsu_dtcm_ctrl_if #(
  parameter int AW     = 16,
  parameter int ITAG_W = 1
);
  logic              lsu_cmd_valid;
  logic              lsu_cmd_ready;
  logic [AW-1:0]     lsu_cmd_addr;
  logic              lsu_cmd_read;
  logic [31:0]       lsu_cmd_wdata;
  logic [3:0]        lsu_cmd_wmask;
  logic [ITAG_W-1:0] lsu_cmd_itag;
  logic              lsu_cmd_usign;
  logic [1:0]        lsu_cmd_size;

  logic              dtcm_cs;
  logic              dtcm_we;
  logic [AW-3:0]     dtcm_addr;
  logic [3:0]        dtcm_wem;
  logic [31:0]       dtcm_din;
  logic [31:0]       dtcm_dout;

  logic              lsu_o_valid;
  logic              lsu_o_ready;
  logic [31:0]       lsu_o_wdat;
  logic [ITAG_W-1:0] lsu_o_itag;
  logic              lsu_o_is_load;
  logic              lsu_o_err;
  logic              lsu_rsp_valid;
  logic              lsu_busy;

  modport slave (
    input  lsu_cmd_valid, lsu_cmd_addr, lsu_cmd_read, lsu_cmd_wdata, lsu_cmd_wmask,
           lsu_cmd_itag, lsu_cmd_usign, lsu_cmd_size, dtcm_dout, lsu_o_ready,
    output lsu_cmd_ready, dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din,
           lsu_o_valid, lsu_o_wdat, lsu_o_itag, lsu_o_is_load, lsu_o_err,
           lsu_rsp_valid, lsu_busy
  );

  modport master (
    output lsu_cmd_valid, lsu_cmd_addr, lsu_cmd_read, lsu_cmd_wdata, lsu_cmd_wmask,
           lsu_cmd_itag, lsu_cmd_usign, lsu_cmd_size, dtcm_dout, lsu_o_ready,
    input  lsu_cmd_ready, dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din,
           lsu_o_valid, lsu_o_wdat, lsu_o_itag, lsu_o_is_load, lsu_o_err,
           lsu_rsp_valid, lsu_busy
  );
endinterface

// File: rtl/lsu_dtcm_ctrl.sv
// DTCM load/store controller: drives the single-port SRAM from AGU commands, aligns load
// data one cycle later in S1, and returns in-order completions through a small FIFO.
module lsu_dtcm_ctrl #(
  parameter int AW     = 16,
  parameter int ITAG_W = 1,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_dtcm_ctrl_if.slave bus
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = OW + 1;

  typedef struct packed {
    logic [31:0]       wdat;
    logic [ITAG_W-1:0] itag;
    logic              is_load;
    logic              err;
  } ent_t;

  ent_t              fifo [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     occ;
  logic              rsp_q;

  logic              s1_v, s1_read, s1_mis, s1_usign;
  logic [1:0]        s1_lane, s1_size;
  logic [ITAG_W-1:0] s1_itag;

  logic              cmd_mis, acc, pop, o_valid;
  logic [CW-1:0]     need;
  logic [31:0]       byte_sh, half_sh, ext;
  ent_t              push_ent;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign cmd_mis = (bus.lsu_cmd_size == 2'b01 && bus.lsu_cmd_addr[0]) ||
                   (bus.lsu_cmd_size == 2'b10 && bus.lsu_cmd_addr[1:0] != 2'b00) ||
                   (bus.lsu_cmd_size == 2'b11);

  assign o_valid           = (occ != '0);
  assign pop               = o_valid & bus.lsu_o_ready;
  // Space check counts the S1 entry that will land this cycle and any slot freed by a pop.
  assign need              = CW'(occ) + CW'(s1_v) - CW'(pop);
  assign bus.lsu_cmd_ready = (need < CW'(DEPTH));
  assign acc               = bus.lsu_cmd_valid & bus.lsu_cmd_ready;

  assign bus.dtcm_cs   = acc & ~cmd_mis;
  assign bus.dtcm_we   = bus.lsu_cmd_valid & ~bus.lsu_cmd_read;
  assign bus.dtcm_addr = bus.lsu_cmd_valid ? bus.lsu_cmd_addr[AW-1:2] : '0;
  assign bus.dtcm_wem  = bus.dtcm_we ? bus.lsu_cmd_wmask : '0;
  assign bus.dtcm_din  = bus.lsu_cmd_valid ? bus.lsu_cmd_wdata : '0;

  assign byte_sh = bus.dtcm_dout >> {s1_lane, 3'b000};
  assign half_sh = bus.dtcm_dout >> {s1_lane[1], 4'b0000};

  always_comb begin
    ext = '0;
    unique case (s1_size)
      2'b00:   ext = {{24{~s1_usign & byte_sh[7]}}, byte_sh[7:0]};
      2'b01:   ext = {{16{~s1_usign & half_sh[15]}}, half_sh[15:0]};
      default: ext = bus.dtcm_dout;
    endcase
  end

  always_comb begin
    push_ent         = '0;
    push_ent.wdat    = (s1_read & ~s1_mis) ? ext : '0;
    push_ent.itag    = s1_itag;
    push_ent.is_load = s1_read;
    push_ent.err     = s1_mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_read  <= 1'b0;
      s1_mis   <= 1'b0;
      s1_usign <= 1'b0;
      s1_lane  <= '0;
      s1_size  <= '0;
      s1_itag  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rsp_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      s1_v  <= acc;
      rsp_q <= pop;
      if (acc) begin
        s1_itag  <= bus.lsu_cmd_itag;
        s1_lane  <= bus.lsu_cmd_addr[1:0];
        s1_size  <= bus.lsu_cmd_size;
        s1_usign <= bus.lsu_cmd_usign;
        s1_read  <= bus.lsu_cmd_read;
        s1_mis   <= cmd_mis;
      end
      if (s1_v) begin
        fifo[wr_ptr] <= push_ent;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({s1_v, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: ;
      endcase
    end
  end

  assign bus.lsu_o_valid   = o_valid;
  assign bus.lsu_o_wdat    = fifo[rd_ptr].wdat;
  assign bus.lsu_o_itag    = fifo[rd_ptr].itag;
  assign bus.lsu_o_is_load = fifo[rd_ptr].is_load;
  assign bus.lsu_o_err     = fifo[rd_ptr].err;
  assign bus.lsu_rsp_valid = rsp_q;
  assign bus.lsu_busy      = s1_v | o_valid;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(s1_v && !pop && occ == OW'(DEPTH)));
endmodule

// File: tb/tb_lsu_dtcm_ctrl.sv
// Randomized scoreboard bench for lsu_dtcm_ctrl with a byte-array memory reference model
// and a behavioural single-port SRAM attached to the DTCM pins.
module tb_lsu_dtcm_ctrl;
  localparam int AW = 16, ITAG_W = 1, DEPTH = 2;

  typedef struct {
    logic [31:0]       wdat;
    logic [ITAG_W-1:0] itag;
    logic              is_load;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_dtcm_ctrl_if #(.AW(AW), .ITAG_W(ITAG_W)) bus ();
  lsu_dtcm_ctrl #(.AW(AW), .ITAG_W(ITAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int   total = 0, bad = 0, npops = 0;
  exp_t exp_q[$];
  logic [7:0]  ref_mem [256] = '{default: 8'h00};
  logic [31:0] sram    [64]  = '{default: 32'h0};

  always @(posedge clk) begin
    if (bus.dtcm_cs) begin
      if (bus.dtcm_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.dtcm_wem[b]) sram[bus.dtcm_addr[5:0]][8*b +: 8] <= bus.dtcm_din[8*b +: 8];
      end else begin
        bus.dtcm_dout <= sram[bus.dtcm_addr[5:0]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic is_mis(input logic [AW-1:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  // Reference: little-endian byte memory, updated in command order.
  function automatic exp_t ref_cmd(input logic [AW-1:0] a, input logic rd, input logic [1:0] sz,
                                   input logic us, input logic [31:0] wd, input logic [3:0] wm,
                                   input logic [ITAG_W-1:0] tg);
    exp_t e;
    int   base, v;
    base = int'(a) % 256;
    e.itag = tg; e.is_load = rd; e.err = is_mis(a, sz); e.wdat = 32'h0;
    if (!e.err && rd) begin
      if (sz == 2'd0) begin
        v = ref_mem[base];
        e.wdat = (!us && v >= 128) ? 32'(v) + 32'hFFFF_FF00 : 32'(v);
      end else if (sz == 2'd1) begin
        v = ref_mem[base] + 256 * ref_mem[base + 1];
        e.wdat = (!us && v >= 32768) ? 32'(v) + 32'hFFFF_0000 : 32'(v);
      end else begin
        e.wdat = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      end
    end else if (!e.err) begin
      for (int i = 0; i < 4; i++)
        if (wm[i]) ref_mem[(base / 4) * 4 + i] = wd[8*i +: 8];
    end
    return e;
  endfunction

  task automatic issue(input logic [AW-1:0] a, input logic rd, input logic [1:0] sz,
                       input logic us, input logic [31:0] wd, input logic [3:0] wm,
                       input logic [ITAG_W-1:0] tg, output logic acc);
    bus.lsu_cmd_valid = 1'b1; bus.lsu_cmd_addr = a; bus.lsu_cmd_read = rd;
    bus.lsu_cmd_size = sz; bus.lsu_cmd_usign = us; bus.lsu_cmd_wdata = wd;
    bus.lsu_cmd_wmask = wm; bus.lsu_cmd_itag = tg;
    @(negedge clk);
    acc = bus.lsu_cmd_ready;
    chk("dtcm_cs", 32'(bus.dtcm_cs), 32'(acc && !is_mis(a, sz)));
    chk("dtcm_we", 32'(bus.dtcm_we), 32'(!rd));
    chk("dtcm_addr", 32'(bus.dtcm_addr), 32'(a) / 4);
    chk("dtcm_wem", 32'(bus.dtcm_wem), rd ? 32'h0 : 32'(wm));
    chk("dtcm_din", bus.dtcm_din, wd);
    if (acc) exp_q.push_back(ref_cmd(a, rd, sz, us, wd, wm, tg));
    @(posedge clk); #1;
    bus.lsu_cmd_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.lsu_cmd_valid = 1'b0;
    @(negedge clk);
    chk("idle_dtcm", {bus.dtcm_din[15:0], bus.dtcm_addr[13:0], bus.dtcm_cs, bus.dtcm_we}, 32'h0);
    chk("idle_wem", 32'(bus.dtcm_wem), 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.lsu_o_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.lsu_busy) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      bad++; total++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  // Single command into an empty pipe with ready high: valid at N+2, rsp pulse at N+3.
  task automatic lat_check(input logic [AW-1:0] a, input logic rd, input logic [1:0] sz,
                           input logic us);
    logic acc;
    drain();
    issue(a, rd, sz, us, 32'h0, 4'h0, 1'b1, acc);
    chk("lat_acc", 32'(acc), 32'h1);
    @(negedge clk); chk("lat_n1_valid", 32'(bus.lsu_o_valid), 32'h0);
    @(negedge clk); chk("lat_n2_valid", 32'(bus.lsu_o_valid), 32'h1);
    @(negedge clk); chk("lat_n3_rsp", 32'(bus.lsu_rsp_valid), 32'h1);
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every completion handshake.
  logic        prev_pop = 1'b0, held = 1'b0;
  logic [31:0] held_wdat;
  logic [2:0]  held_side;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pop = 1'b0; held = 1'b0;
    end else begin
      logic pop;
      exp_t e;
      chk("rsp_valid", 32'(bus.lsu_rsp_valid), 32'(prev_pop));
      if (held && bus.lsu_o_valid) begin
        chk("stable_wdat", bus.lsu_o_wdat, held_wdat);
        chk("stable_side", 32'({bus.lsu_o_itag, bus.lsu_o_is_load, bus.lsu_o_err}), 32'(held_side));
      end
      pop = bus.lsu_o_valid & bus.lsu_o_ready;
      if (pop) begin
        npops++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion wdat=%h required=none", bus.lsu_o_wdat);
        end else begin
          e = exp_q.pop_front();
          chk("o_wdat", bus.lsu_o_wdat, e.wdat);
          chk("o_itag", 32'(bus.lsu_o_itag), 32'(e.itag));
          chk("o_is_load", 32'(bus.lsu_o_is_load), 32'(e.is_load));
          chk("o_err", 32'(bus.lsu_o_err), 32'(e.err));
        end
      end
      held = bus.lsu_o_valid & ~bus.lsu_o_ready;
      held_wdat = bus.lsu_o_wdat;
      held_side = {bus.lsu_o_itag, bus.lsu_o_is_load, bus.lsu_o_err};
      prev_pop = pop;
    end
  end

  initial begin
    logic acc;
    int   cnt, p0;
    logic [AW-1:0] a;
    logic [1:0] sz;
    bus.lsu_cmd_valid = 1'b0; bus.lsu_cmd_addr = '0; bus.lsu_cmd_read = 1'b0;
    bus.lsu_cmd_wdata = '0; bus.lsu_cmd_wmask = '0; bus.lsu_cmd_itag = '0;
    bus.lsu_cmd_usign = 1'b0; bus.lsu_cmd_size = '0; bus.lsu_o_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_o_valid", 32'(bus.lsu_o_valid), 32'h0);
    chk("rst_busy", 32'(bus.lsu_busy), 32'h0);
    chk("rst_rsp", 32'(bus.lsu_rsp_valid), 32'h0);
    chk("rst_cmd_ready", 32'(bus.lsu_cmd_ready), 32'h1);
    chk("rst_cs", 32'(bus.dtcm_cs), 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) idle_cycle();
    chk("idle_ready", 32'(bus.lsu_cmd_ready), 32'h1);

    for (int w = 0; w < 64; w++) issue(AW'(w * 4), 1'b0, 2'd2, 1'b0, $urandom, 4'hF, 1'b0, acc);

    // Directed cases
    drain();
    issue(16'h0000, 1'b0, 2'd2, 1'b0, 32'h80FF_1234, 4'hF, 1'b0, acc);
    lat_check(16'h0003, 1'b1, 2'd0, 1'b0);
    lat_check(16'h0003, 1'b1, 2'd0, 1'b1);
    issue(16'h0012, 1'b0, 2'd1, 1'b0, 32'hBEEF_BEEF, 4'b1100, 1'b1, acc);
    lat_check(16'h0012, 1'b1, 2'd1, 1'b1);
    lat_check(16'h0006, 1'b1, 2'd2, 1'b0);

    // Backpressure: only DEPTH commands get in while completions are held.
    drain();
    bus.lsu_o_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      issue(AW'(4 * i), 1'b1, 2'd2, 1'b0, 32'h0, 4'h0, ITAG_W'(i), acc);
      if (acc) cnt++;
    end
    chk("bp_accepted", 32'(cnt), 32'(DEPTH));
    chk("bp_ready_low", 32'(bus.lsu_cmd_ready), 32'h0);
    p0 = npops;
    bus.lsu_o_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_b2b_pops", 32'(npops - p0), 32'(DEPTH));

    // Reset with the FIFO full
    drain();
    bus.lsu_o_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(AW'(8 * i), 1'b1, 2'd2, 1'b0, 32'h0, 4'h0, ITAG_W'(i), acc);
    chk("pre_rst_valid", 32'(bus.lsu_o_valid), 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 32'(bus.lsu_o_valid), 32'h0);
    chk("mid_rst_busy", 32'(bus.lsu_busy), 32'h0);
    chk("mid_rst_ready", 32'(bus.lsu_cmd_ready), 32'h1);
    @(posedge clk); #1; rst_n = 1'b1; bus.lsu_o_ready = 1'b1;
    lat_check(16'h0000, 1'b1, 2'd2, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.lsu_o_ready = ($urandom % 4) != 0;
      if (($urandom % 5) == 0) begin
        idle_cycle();
      end else begin
        sz = 2'($urandom % 4);
        a  = AW'($urandom % 256);
        if (($urandom % 4) != 0 && sz != 2'd3) a = (sz == 2'd0) ? a : (sz == 2'd1) ? (a & ~AW'(1)) : (a & ~AW'(3));
        issue(a, 1'($urandom), sz, 1'($urandom), $urandom, 4'($urandom),
              ITAG_W'($urandom), acc);
      end
    end
    drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1);
  end
endmodule
